// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decode-side control, ROM port and issued-instruction outputs.
// The environment (decoder + ROM) is the master; fetch_stage is the slave.
interface fetch_stage_if #(
   parameter int ADDR_W = 12
);
   logic              stall;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic [ADDR_W-1:0] address_imem;
   logic [31:0]       imem_data;
   logic [31:0]       q_imem;
   logic [31:0]       pc_out;
   logic [31:0]       pc_plus1;
   logic              inst_valid;

   modport master (
      output stall, redirect, redirect_pc, imem_data,
      input  address_imem, q_imem, pc_out, pc_plus1, inst_valid
   );

   modport slave (
      input  stall, redirect, redirect_pc, imem_data,
      output address_imem, q_imem, pc_out, pc_plus1, inst_valid
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, hides the one-cycle ROM latency with a
// request tracker and a one-entry skid buffer, supports stall and redirect.
module fetch_stage #(
   parameter int          ADDR_W   = 12,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic          clock,
   input  logic          resetn,
   fetch_stage_if.slave  bus
);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        req_valid_q, req_valid_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic [31:0] out_pc_q, out_pc_d;

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      req_valid_d  = req_valid_q;
      req_pc_d     = req_pc_q;
      skid_valid_d = skid_valid_q;
      skid_inst_d  = skid_inst_q;
      skid_pc_d    = skid_pc_q;
      out_valid_d  = out_valid_q;
      out_inst_d   = out_inst_q;
      out_pc_d     = out_pc_q;

      if (bus.redirect) begin
         // Dropping req_valid squashes the wrong-path word still in the ROM.
         fetch_pc_d   = bus.redirect_pc;
         req_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         out_valid_d  = 1'b0;
         out_inst_d   = 32'd0;
      end else if (bus.stall) begin
         req_valid_d = 1'b0;
         if (req_valid_q) begin
            skid_valid_d = 1'b1;
            skid_inst_d  = bus.imem_data;
            skid_pc_d    = req_pc_q;
         end
      end else begin
         req_valid_d = 1'b1;
         req_pc_d    = fetch_pc_q;
         fetch_pc_d  = fetch_pc_q + 32'd1;
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_inst_d   = skid_inst_q;
            out_pc_d     = skid_pc_q;
            skid_valid_d = 1'b0;
         end else if (req_valid_q) begin
            out_valid_d = 1'b1;
            out_inst_d  = bus.imem_data;
            out_pc_d    = req_pc_q;
         end else begin
            out_valid_d = 1'b0;
            out_inst_d  = 32'd0;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         fetch_pc_q   <= RESET_PC;
         req_valid_q  <= 1'b0;
         req_pc_q     <= 32'd0;
         skid_valid_q <= 1'b0;
         skid_inst_q  <= 32'd0;
         skid_pc_q    <= 32'd0;
         out_valid_q  <= 1'b0;
         out_inst_q   <= 32'd0;
         out_pc_q     <= 32'd0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         req_valid_q  <= req_valid_d;
         req_pc_q     <= req_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_inst_q  <= skid_inst_d;
         skid_pc_q    <= skid_pc_d;
         out_valid_q  <= out_valid_d;
         out_inst_q   <= out_inst_d;
         out_pc_q     <= out_pc_d;
      end
   end

   assign bus.address_imem = fetch_pc_q[ADDR_W-1:0];
   assign bus.q_imem       = out_inst_q;
   assign bus.pc_out       = out_pc_q;
   assign bus.pc_plus1     = out_pc_q + 32'd1;
   assign bus.inst_valid   = out_valid_q;

`ifndef SYNTHESIS
   // A stall always drains the in-flight word into an empty skid, so both can never hold data.
   a_skid_arrival_exclusive : assert property (
      @(posedge clock) disable iff (!resetn) !(skid_valid_q && req_valid_q)
   );
`endif

endmodule
